// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared types and default address map for the APB bridge controller
package apb_bridge_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SLV_NONE, SLV_UART, SLV_GPIO} slv_t;

    localparam logic [31:0] UART_BASE_DEF   = 32'h0000_1000;
    localparam logic [31:0] GPIO_BASE_DEF   = 32'h0000_2000;
    localparam int          REGION_BITS_DEF = 12;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a byte address to the APB slave whose region it hits
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter logic [31:0] UART_BASE   = UART_BASE_DEF,
    parameter logic [31:0] GPIO_BASE   = GPIO_BASE_DEF,
    parameter int          REGION_BITS = REGION_BITS_DEF
) (
    input  logic [31:0] addr,
    output slv_t        slv
);

    logic uart_hit;
    logic gpio_hit;

    // Only the bits above the region offset take part; UART wins on overlap
    always_comb begin
        uart_hit = ((addr ^ UART_BASE) >> REGION_BITS) == 32'd0;
        gpio_hit = ((addr ^ GPIO_BASE) >> REGION_BITS) == 32'd0;
        slv      = uart_hit ? SLV_UART : gpio_hit ? SLV_GPIO : SLV_NONE;
    end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl: sequences single host transfers onto the shared UART/GPIO APB bus
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter logic [31:0] UART_BASE   = UART_BASE_DEF,
    parameter logic [31:0] GPIO_BASE   = GPIO_BASE_DEF,
    parameter int          REGION_BITS = REGION_BITS_DEF,
    parameter int          TIMEOUT     = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL_uart,
    output logic        PSEL_gpio,
    input  logic [31:0] PRDATA_uart,
    input  logic [31:0] PRDATA_gpio,
    input  logic        PREADY_uart,
    input  logic        PREADY_gpio
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state, state_n;
    slv_t          slv_q, slv_n, dec_slv;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   paddr_n, pwdata_n, rdata_n, prdata_sel;
    logic          pwrite_n, err_n, accept, pready_sel;

    apb_addr_decoder #(
        .UART_BASE  (UART_BASE),
        .GPIO_BASE  (GPIO_BASE),
        .REGION_BITS(REGION_BITS)
    ) u_dec (
        .addr(req_addr),
        .slv (dec_slv)
    );

    assign req_ready  = (state == IDLE) || (state == DONE);
    assign accept     = req_valid && req_ready;
    assign pready_sel = (slv_q == SLV_UART) ? PREADY_uart : PREADY_gpio;
    assign prdata_sel = (slv_q == SLV_UART) ? PRDATA_uart : PRDATA_gpio;

    always_comb begin
        state_n  = state;
        slv_n    = slv_q;
        cnt_n    = cnt;
        paddr_n  = PADDR;
        pwdata_n = PWDATA;
        pwrite_n = PWRITE;
        err_n    = rsp_err;
        rdata_n  = rsp_rdata;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    paddr_n  = req_addr;
                    pwdata_n = req_wdata;
                    pwrite_n = req_write;
                    slv_n    = dec_slv;
                    state_n  = (dec_slv == SLV_NONE) ? DONE : SETUP;
                    err_n    = (dec_slv == SLV_NONE);
                    rdata_n  = 32'd0;
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            SETUP: begin
                state_n = ACCESS;
                cnt_n   = '0;
            end
            ACCESS: begin
                // A ready on the final allowed cycle counts as success
                if (pready_sel) begin
                    state_n = DONE;
                    err_n   = 1'b0;
                    rdata_n = PWRITE ? 32'd0 : prdata_sel;
                end else if (cnt == CNT_MAX) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    rdata_n = 32'd0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with it
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            slv_q     <= SLV_NONE;
            cnt       <= '0;
            PADDR     <= 32'd0;
            PWDATA    <= 32'd0;
            PWRITE    <= 1'b0;
            PENABLE   <= 1'b0;
            PSEL_uart <= 1'b0;
            PSEL_gpio <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            state     <= state_n;
            slv_q     <= slv_n;
            cnt       <= cnt_n;
            PADDR     <= paddr_n;
            PWDATA    <= pwdata_n;
            PWRITE    <= pwrite_n;
            PENABLE   <= (state_n == ACCESS);
            PSEL_uart <= (state_n == SETUP || state_n == ACCESS) && slv_n == SLV_UART;
            PSEL_gpio <= (state_n == SETUP || state_n == ACCESS) && slv_n == SLV_GPIO;
            rsp_valid <= (state_n == DONE);
            rsp_err   <= err_n;
            rsp_rdata <= rdata_n;
        end
    end

endmodule
